// File: rtl/soc_ahb_ram_pkg.sv
// Shared types and constants for the AHB-Lite front end of the single-port FPGA RAM.
package soc_ahb_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_DLY = 3'd2,
    ST_WR     = 3'd3,
    ST_RMW_RD = 3'd4,
    ST_RMW_WR = 3'd5,
    ST_ERR1   = 3'd6,
    ST_ERR2   = 3'd7
  } state_e;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/soc_ahb_ram_merge.sv
// Byte-lane mask from transfer size/offset, and merge of new lanes into the old RAM word.
module soc_ahb_ram_merge
  import soc_ahb_ram_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  output logic [3:0]  lane_mask,
  output logic [31:0] merged
);

  // Lane mask decode followed by per-lane select; a word transfer replaces every lane.
  always_comb begin
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/soc_ahb_ram_ctrl.sv
// AHB-Lite slave driving a single-port RAM: zero-wait reads and word writes,
// sub-word writes as read-modify-write, port conflicts stalled with HREADYOUT.
module soc_ahb_ram_ctrl
  import soc_ahb_ram_pkg::*;
#(
  parameter int ADDRWIDTH = 14
) (
  input  logic                 HCLK,
  input  logic                 HRST,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [31:0]          RamWdata,
  output logic                 RamWe,
  input  logic [31:0]          RamRdata
);

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [1:0]           lane_q, lane_d;
  logic [2:0]           size_q, size_d;
  logic                 write_q, write_d;
  logic                 hreadyout_q, hreadyout_d;
  logic                 hresp_q, hresp_d;
  logic                 ram_we_q, ram_we_d;

  logic                 accept_s, legal_s, port_free_s, take_s;
  logic [ADDRWIDTH-1:0] haddr_word_s;
  logic [3:0]           lane_mask_s;
  logic [31:0]          merged_s;
  logic                 unused_s;

  assign haddr_word_s = HADDR[ADDRWIDTH+1:2];
  assign unused_s     = ^{HADDR[31:ADDRWIDTH+2], lane_mask_s};

  // In WR the captured size is a word, so the merge passes HWDATA through untouched.
  soc_ahb_ram_merge u_merge (
    .size      (size_q),
    .addr_lo   (lane_q),
    .old_data  (RamRdata),
    .new_data  (HWDATA),
    .lane_mask (lane_mask_s),
    .merged    (merged_s)
  );

  always_comb begin
    accept_s    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    legal_s     = xfer_legal(HSIZE, HADDR[1:0]);
    port_free_s = (state_q == ST_IDLE) | (state_q == ST_RD) | (state_q == ST_ERR2);
    take_s      = accept_s & (port_free_s | (state_q == ST_WR) | (state_q == ST_RMW_WR));
    if (take_s) begin
      addr_d  = haddr_word_s;
      lane_d  = HADDR[1:0];
      size_d  = HSIZE;
      write_d = HWRITE;
    end else begin
      addr_d  = addr_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RD_DLY: state_d = ST_RD;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_ERR1:   state_d = ST_ERR2;
      ST_IDLE, ST_RD, ST_ERR2, ST_WR, ST_RMW_WR: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (!legal_s) begin
          state_d = ST_ERR1;
        end else if (!HWRITE) begin
          // A read arriving while the port is writing waits one cycle for its RAM slot.
          state_d = port_free_s ? ST_RD : ST_RD_DLY;
        end else if (HSIZE == HSIZE_WORD) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RMW_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_d = !(state_d inside {ST_RD_DLY, ST_RMW_RD, ST_ERR1});
    hresp_d     = (state_d inside {ST_ERR1, ST_ERR2}) ? RESP_ERROR : RESP_OKAY;
    ram_we_d    = (state_d == ST_WR) | (state_d == ST_RMW_WR);
    RamAddr     = port_free_s ? haddr_word_s : addr_q;
    RamWdata    = merged_s;
    RamWe       = ram_we_q & write_q;
    HRDATA      = (state_q == ST_RD) ? RamRdata : 32'h0000_0000;
    HREADYOUT   = hreadyout_q;
    HRESP       = hresp_q;
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lane_q      <= 2'b00;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      ram_we_q    <= ram_we_d;
    end
  end

endmodule

// File: tb/tb_soc_ahb_ram_ctrl.sv
// Self-checking bench: AHB master driving transaction queues, a behavioural RAM,
// and a transaction-level reference model of memory contents, waits and responses.
module tb_soc_ahb_ram_ctrl;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRST;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [AW-1:0] RamAddr;
  logic [31:0]   RamWdata;
  logic          RamWe;
  logic [31:0]   RamRdata;

  soc_ahb_ram_ctrl #(.ADDRWIDTH(AW)) dut (
    .HCLK(HCLK), .HRST(HRST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .RamAddr(RamAddr), .RamWdata(RamWdata), .RamWe(RamWe), .RamRdata(RamRdata)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  // Behavioural single-port RAM with a backdoor preload port
  logic [31:0]   mem [0:DEPTH-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  int            we_cnt = 0;

  always @(posedge HCLK) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (RamWe === 1'b1) begin
      mem[RamAddr] <= RamWdata;
      we_cnt <= we_cnt + 1;
    end else begin
      RamRdata <= mem[RamAddr];
    end
  end

  typedef struct {
    bit          sel;
    bit          valid;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  txn_t        q[$];
  int          touched[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          checks = 0;
  int          failures = 0;
  int          exp_writes = 0;
  bit          prev_write = 1'b0;

  function automatic txn_t mk(bit sel, bit valid, bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] data);
    txn_t t;
    t.sel = sel; t.valid = valid; t.wr = wr; t.addr = addr; t.size = size; t.data = data;
    return t;
  endfunction

  function automatic bit legal(logic [2:0] size, logic [1:0] lo);
    return (size == 3'd0) || (size == 3'd1 && !lo[0]) || (size == 3'd2 && lo == 2'd0);
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_addr = AW'(word_of(addr));
    pl_data = data;
    pl_en   = 1'b1;
    ref_mem[word_of(addr)] = data;
    @(posedge HCLK); #1;
    pl_en = 1'b0;
  endtask

  // Bus-level rules: errors and sub-word writes cost one wait, as does a read right after a write.
  task automatic model_txn(input txn_t t, output int w_exp, output bit resp_exp,
                           output bit rd_exp, output logic [31:0] rd_data);
    int w;
    int lo;
    w = word_of(t.addr);
    lo = int'(t.addr[1:0]);
    w_exp = 0; resp_exp = 1'b0; rd_exp = 1'b0; rd_data = 32'h0;
    if (t.valid) touched.push_back(w);
    if (!(t.sel && t.valid)) begin
      prev_write = 1'b0;
    end else if (!legal(t.size, t.addr[1:0])) begin
      w_exp = 1; resp_exp = 1'b1; prev_write = 1'b0;
    end else if (t.wr) begin
      w_exp = (t.size == 3'd2) ? 0 : 1;
      for (int b = 0; b < 4; b++) begin
        if (t.size == 3'd2 || (t.size == 3'd1 && b / 2 == lo / 2) || (t.size == 3'd0 && b == lo))
          ref_mem[w][8*b +: 8] = t.data[8*b +: 8];
      end
      exp_writes++;
      prev_write = 1'b1;
    end else begin
      w_exp = prev_write ? 1 : 0;
      rd_exp = 1'b1;
      rd_data = ref_mem[w];
      prev_write = 1'b0;
    end
  endtask

  task automatic run_queue(input string name);
    txn_t        cur;
    bit          have_cur;
    bit          done;
    int          waits, exp_waits, we0, ew0, n;
    bit          exp_resp, exp_rd;
    logic [31:0] exp_rdata;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
    n = q.size();
    we0 = we_cnt;
    ew0 = exp_writes;
    have_cur = 1'b0;
    exp_waits = 0; exp_resp = 1'b0; exp_rd = 1'b0; exp_rdata = 32'h0;
    @(posedge HCLK); #1;
    for (int i = 0; i < n; i++) begin
      HSEL   = q[i].sel;
      HTRANS = q[i].valid ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
      HADDR  = q[i].addr;
      HWRITE = q[i].wr;
      HSIZE  = q[i].size;
      waits  = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge HCLK);
        if (have_cur) begin
          checks++;
          if (HRESP !== exp_resp) begin
            failures++;
            $display("FAIL %s hresp txn%0d: got %b expected %b", name, i - 1, HRESP, exp_resp);
          end
          checks++;
          if (HREADYOUT === 1'b1 && exp_rd) begin
            if (HRDATA !== exp_rdata) begin
              failures++;
              $display("FAIL %s hrdata txn%0d: got %h expected %h", name, i - 1, HRDATA, exp_rdata);
            end
          end else if (HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL %s hrdata_zero txn%0d: got %h expected 00000000", name, i - 1, HRDATA);
          end
        end
        if (HREADYOUT === 1'b1) begin
          done = 1'b1;
        end else begin
          waits++;
          if (waits > 4) begin
            checks++;
            failures++;
            $display("FAIL %s timeout txn%0d: got %0d waits expected %0d", name, i - 1, waits, exp_waits);
            done = 1'b1;
          end
        end
      end
      @(posedge HCLK); #1;
      if (have_cur) begin
        checks++;
        if (waits != exp_waits) begin
          failures++;
          $display("FAIL %s waits txn%0d: got %0d expected %0d", name, i - 1, waits, exp_waits);
        end
      end
      cur = q[i];
      model_txn(cur, exp_waits, exp_resp, exp_rd, exp_rdata);
      HWDATA = (cur.sel && cur.valid && cur.wr) ? cur.data : $urandom;
      have_cur = 1'b1;
    end
    checks++;
    if ((we_cnt - we0) != (exp_writes - ew0)) begin
      failures++;
      $display("FAIL %s ram_we_count: got %0d expected %0d", name, we_cnt - we0, exp_writes - ew0);
    end
    foreach (touched[k]) begin
      checks++;
      if (mem[touched[k]] !== ref_mem[touched[k]]) begin
        failures++;
        $display("FAIL %s mem[%0h]: got %h expected %h", name, touched[k], mem[touched[k]], ref_mem[touched[k]]);
      end
    end
    touched.delete();
    q.delete();
  endtask

  task automatic check_word(input string name, input int w, input logic [31:0] exp);
    checks++;
    if (mem[w] !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, mem[w], exp);
    end
  endtask

  task automatic test_reset();
    HRST = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    checks += 4;
    if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
    if (HRESP !== 1'b0)     begin failures++; $display("FAIL reset_hresp: got %b expected 0", HRESP); end
    if (RamWe !== 1'b0)     begin failures++; $display("FAIL reset_ramwe: got %b expected 0", RamWe); end
    if (HRDATA !== 32'h0)   begin failures++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
    @(negedge HCLK);
    HRST = 1'b0;
  endtask

  task automatic test_back_to_back_reads();
    preload(32'h0000_0000, 32'h1122_3344);
    preload(32'h0000_0004, 32'h5566_7788);
    q.push_back(mk(1, 1, 0, 32'h0000_0000, 3'd2, 32'h0));
    q.push_back(mk(1, 1, 0, 32'h0000_0004, 3'd2, 32'h0));
    run_queue("b2b_reads");
  endtask

  task automatic test_write_then_read();
    q.push_back(mk(1, 1, 1, 32'h0000_0008, 3'd2, 32'hDEAD_BEEF));
    q.push_back(mk(1, 1, 0, 32'h0000_0008, 3'd2, 32'h0));
    run_queue("wr_rd");
    check_word("wr_rd_word", 2, 32'hDEAD_BEEF);
  endtask

  task automatic test_rmw();
    preload(32'h0000_0010, 32'h1122_3344);
    q.push_back(mk(1, 1, 1, 32'h0000_0012, 3'd0, 32'h00AA_0000));
    run_queue("rmw_byte");
    check_word("rmw_byte_word", 4, 32'h11AA_3344);
    q.push_back(mk(1, 1, 1, 32'h0000_0010, 3'd1, 32'h0000_BBCC));
    q.push_back(mk(1, 1, 0, 32'h0000_0010, 3'd2, 32'h0));
    run_queue("rmw_half");
    check_word("rmw_half_word", 4, 32'h11AA_BBCC);
  endtask

  task automatic test_illegal();
    preload(32'h0000_0020, 32'hCAFE_F00D);
    q.push_back(mk(1, 1, 1, 32'h0000_0020, 3'd3, 32'hFFFF_FFFF));
    q.push_back(mk(1, 1, 1, 32'h0000_0021, 3'd1, 32'hFFFF_FFFF));
    q.push_back(mk(1, 1, 1, 32'h0000_0022, 3'd2, 32'hFFFF_FFFF));
    q.push_back(mk(1, 1, 0, 32'h0000_0020, 3'd2, 32'h0));
    run_queue("illegal");
    check_word("illegal_word", 8, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_rmw();
    int we0;
    preload(32'h0000_0040, 32'hA5A5_5A5A);
    we0 = we_cnt;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd0; HADDR = 32'h0000_0041;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_5500;
    @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b0) begin failures++; $display("FAIL rst_mid_wait: got %b expected 0", HREADYOUT); end
    HRST = 1'b1;
    #1;
    checks += 4;
    if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_mid_hreadyout: got %b expected 1", HREADYOUT); end
    if (HRESP !== 1'b0)     begin failures++; $display("FAIL rst_mid_hresp: got %b expected 0", HRESP); end
    if (RamWe !== 1'b0)     begin failures++; $display("FAIL rst_mid_ramwe: got %b expected 0", RamWe); end
    if (HRDATA !== 32'h0)   begin failures++; $display("FAIL rst_mid_hrdata: got %h expected 0", HRDATA); end
    @(posedge HCLK);
    @(negedge HCLK);
    HRST = 1'b0;
    prev_write = 1'b0;
    check_word("rst_mid_word", 16, 32'hA5A5_5A5A);
    checks++;
    if (we_cnt != we0) begin failures++; $display("FAIL rst_mid_we_count: got %0d expected %0d", we_cnt - we0, 0); end
    q.push_back(mk(1, 1, 0, 32'h0000_0040, 3'd2, 32'h0));
    run_queue("rst_mid_read");
  endtask

  task automatic test_alias_unselected();
    q.push_back(mk(1, 1, 0, 32'h0001_0004, 3'd2, 32'h0));
    q.push_back(mk(0, 1, 1, 32'h0000_0004, 3'd2, 32'h0BAD_0BAD));
    q.push_back(mk(1, 0, 1, 32'h0000_0004, 3'd2, 32'h0BAD_0BAD));
    q.push_back(mk(1, 1, 0, 32'h0000_0004, 3'd2, 32'h0));
    run_queue("alias_unsel");
    check_word("alias_unsel_word", 1, 32'h5566_7788);
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) preload((32'h100 + 32'(k)) << 2, $urandom);
    for (int k = 0; k < 150; k++) begin
      int          r;
      int          szr;
      int          lo;
      logic [2:0]  sz;
      logic [31:0] a;
      r   = $urandom_range(0, 19);
      szr = $urandom_range(0, 9);
      sz  = (szr < 3) ? 3'd0 : (szr < 6) ? 3'd1 : (szr < 9) ? 3'd2 : 3'd3;
      lo  = $urandom_range(0, 3);
      if (sz == 3'd2 && $urandom_range(0, 3) != 0) lo = 0;
      a = (32'($urandom_range(0, 3)) << 16) | ((32'h100 + 32'($urandom_range(0, 15))) << 2) | 32'(lo);
      q.push_back(mk(r != 0, r != 1, 1'($urandom_range(0, 1)), a, sz, $urandom));
    end
    run_queue("random");
  endtask

  initial begin
    test_reset();
    test_back_to_back_reads();
    test_write_then_read();
    test_rmw();
    test_illegal();
    test_reset_mid_rmw();
    test_alias_unselected();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
